// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM states, round constants,
// S-box table and GF(2^8) multiply helpers.
package aes_pkg;

    localparam int NB        = 4;
    localparam int NK        = 4;
    localparam int NR_AES128 = 10;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } fsm_e;

    // Byte 0x00 sits in the top byte, so entry x lives at
    // bit offset 8*(255-x) = {~x, 3'b000}.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul02(input logic [7:0] x);
        return xtime(x);
    endfunction

    function automatic logic [7:0] mul03(input logic [7:0] x);
        return xtime(x) ^ x;
    endfunction

endpackage

// File: rtl/aes_round_unit.sv
// One combinational AES-128 round plus on-the-fly key step.
// Ports: state_in/rk_in (128), rcon_in (8), last -> state_out/rk_out.
module aes_round_unit
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] rk_in,
    input  logic [7:0]   rcon_in,
    input  logic         last,
    output logic [127:0] state_out,
    output logic [127:0] rk_out
);

    logic [31:0] rot;
    logic [31:0] tmp;
    logic [31:0] n0, n1, n2, n3;

    assign rot = {rk_in[23:0], rk_in[31:24]};
    assign tmp = {sbox(rot[31:24]) ^ rcon_in,
                  sbox(rot[23:16]),
                  sbox(rot[15:8]),
                  sbox(rot[7:0])};
    assign n0 = rk_in[127:96] ^ tmp;
    assign n1 = rk_in[95:64]  ^ n0;
    assign n2 = rk_in[63:32]  ^ n1;
    assign n3 = rk_in[31:0]   ^ n2;
    assign rk_out = {n0, n1, n2, n3};

    genvar c, r;
    for (c = 0; c < 4; c++) begin : g_col
        logic [7:0]  b [4];
        logic [31:0] mc;

        // SubBytes fused with ShiftRows: row r rotates left by r.
        for (r = 0; r < 4; r++) begin : g_row
            assign b[r] = sbox(
                state_in[127-8*(4*((c+r)%4)+r) -: 8]);
        end

        assign mc = {
            mul02(b[0]) ^ mul03(b[1]) ^ b[2] ^ b[3],
            b[0] ^ mul02(b[1]) ^ mul03(b[2]) ^ b[3],
            b[0] ^ b[1] ^ mul02(b[2]) ^ mul03(b[3]),
            mul03(b[0]) ^ b[1] ^ b[2] ^ mul02(b[3])
        };

        assign state_out[127-32*c -: 32] =
            (last ? {b[0], b[1], b[2], b[3]} : mc)
            ^ rk_out[127-32*c -: 32];
    end

endmodule

// File: rtl/aes_enc_sequencer.sv
// Iterative AES-128 encrypt: one round per cycle, keys made on the fly.
// in_* handshake loads a block, out_* handshake returns ciphertext.
module aes_enc_sequencer
    import aes_pkg::*;
#(
    parameter int NR = 10,
    parameter int DW = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [DW-1:0] in_key,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          busy,
    output logic [3:0]    round_idx
);

    if (NR != NR_AES128 || DW != 128) begin : g_bad_cfg
        $error("aes_enc_sequencer supports only NR=10, DW=128");
    end

    localparam logic [3:0] LAST_RND = 4'(NR);

    fsm_e         fsm_q, fsm_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] st_nx, rk_nx;

    aes_round_unit u_round (
        .state_in  (st_q),
        .rk_in     (rk_q),
        .rcon_in   (rcon(rnd_q)),
        .last      (rnd_q == LAST_RND),
        .state_out (st_nx),
        .rk_out    (rk_nx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q <= IDLE;
            rnd_q <= 4'd0;
            st_q  <= '0;
            rk_q  <= '0;
        end else begin
            fsm_q <= fsm_d;
            rnd_q <= rnd_d;
            st_q  <= st_d;
            rk_q  <= rk_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        rnd_d = rnd_q;
        st_d  = st_q;
        rk_d  = rk_q;
        if (flush) begin
            // Abort only; datapath registers keep their contents.
            fsm_d = IDLE;
            rnd_d = 4'd0;
        end else begin
            unique case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        fsm_d = ROUND;
                        rnd_d = 4'd1;
                        st_d  = in_data ^ in_key;
                        rk_d  = in_key;
                    end
                end
                ROUND: begin
                    st_d = st_nx;
                    rk_d = rk_nx;
                    if (rnd_q == LAST_RND) begin
                        fsm_d = DONE;
                    end else begin
                        rnd_d = rnd_q + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm_d = IDLE;
                        rnd_d = 4'd0;
                    end
                end
                default: begin
                    fsm_d = IDLE;
                    rnd_d = 4'd0;
                end
            endcase
        end
    end

    assign in_ready  = (fsm_q == IDLE);
    assign out_valid = (fsm_q == DONE);
    assign busy      = (fsm_q == ROUND) || (fsm_q == DONE);
    assign out_data  = st_q;
    assign round_idx = (fsm_q == IDLE) ? 4'd0 : rnd_q;

endmodule

// File: tb/tb_aes_enc_sequencer.sv
// Bench for aes_enc_sequencer: known-answer table plus handshake,
// backpressure, flush and reset sequences with a ciphertext scoreboard.
module tb_aes_enc_sequencer;

    logic         clk = 1'b0;
    logic         rst_n, flush, in_valid, out_ready;
    logic         in_ready, out_valid, busy;
    logic [127:0] in_data, in_key, out_data;
    logic [3:0]   round_idx;

    always #5 clk = ~clk;

    aes_enc_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .round_idx (round_idx)
    );

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
    } vec_t;

    vec_t         tbl [4];
    int           errors = 0, checks = 0;
    int           cyc = 0, n_acc = 0, n_del = 0;
    int           acc_edge = 0, del_edge = 0;
    logic [127:0] cur_ct;
    logic [127:0] sb_q [$];

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Evaluate the handshakes for the coming edge, then advance to
    // the next falling edge where outputs are checked.
    task automatic tick();
        #1;
        if (!rst_n || flush) begin
            sb_q.delete();
        end else begin
            if (in_valid && in_ready) begin
                sb_q.push_back(cur_ct);
                n_acc++;
                acc_edge = cyc;
            end
            if (out_valid && out_ready) begin
                n_del++;
                del_edge = cyc;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h expected none",
                             out_data);
                end else begin
                    chk("scoreboard", out_data, sb_q.pop_front());
                end
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 30) begin
            tick();
            n++;
        end
        chk_i("ready_wait", int'(in_ready), 1);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
        chk_i("valid_wait", int'(out_valid), 1);
    endtask

    task automatic drive(input int i);
        in_data = tbl[i].pt;
        in_key  = tbl[i].key;
        cur_ct  = tbl[i].ct;
    endtask

    task automatic chk_reset();
        chk_i("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", out_data, 128'h0);
        chk_i("rst_busy", int'(busy), 0);
        chk_i("rst_round_idx", int'(round_idx), 0);
        chk_i("rst_in_ready", int'(in_ready), 1);
    endtask

    task automatic run_block(input int i, input bit walk);
        int n = 0;
        wait_ready();
        drive(i);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk_i("accept_busy", int'(busy), 1);
        while (!out_valid && n < 20) begin
            if (walk) begin
                chk_i("round_idx", int'(round_idx), n + 1);
            end
            if (walk && n == 1) begin
                chk("rk_round1", dut.rk_q,
                    128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
            end
            tick();
            n++;
        end
        chk_i("latency", n, 10);
        chk_i("done_round_idx", int'(round_idx), 10);
        tick();
        chk_i("handoff_valid", int'(out_valid), 0);
        chk_i("handoff_ready", int'(in_ready), 1);
    endtask

    initial begin
        int a, d, n, seen;

        tbl[0] = '{128'h00112233445566778899aabbccddeeff,
                   128'h000102030405060708090a0b0c0d0e0f,
                   128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        tbl[1] = '{128'h3243f6a8885a308d313198a2e0370734,
                   128'h2b7e151628aed2a6abf7158809cf4f3c,
                   128'h3925841d02dc09fbdc118597196a0b32};
        tbl[2] = '{128'h00000000000000000000000000000000,
                   128'h00000000000000000000000000000000,
                   128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
        tbl[3] = '{128'h6bc1bee22e409f96e93d7e117393172a,
                   128'h2b7e151628aed2a6abf7158809cf4f3c,
                   128'h3ad77bb40d7a3660a89ecaf32466ef97};

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        in_key    = '0;
        cur_ct    = '0;
        @(negedge clk);
        tick();
        tick();
        rst_n = 1'b1;
        chk_reset();

        for (int i = 0; i < 4; i++) begin
            run_block(i, i == 0);
        end
        chk_i("table_delivered", n_del, 4);

        // Backpressure with inputs scrambled during the rounds.
        wait_ready();
        drive(0);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            in_data = {$urandom, $urandom, $urandom, $urandom};
            in_key  = {$urandom, $urandom, $urandom, $urandom};
            chk_i("bp_round_ready", int'(in_ready), 0);
            tick();
            n++;
        end
        chk_i("bp_latency", n, 10);
        for (int k = 0; k < 7; k++) begin
            chk("bp_hold_data", out_data, tbl[0].ct);
            chk_i("bp_hold_ready", int'(in_ready), 0);
            chk_i("bp_hold_valid", int'(out_valid), 1);
            tick();
        end
        d = n_del;
        out_ready = 1'b1;
        tick();
        chk_i("bp_release", n_del, d + 1);

        // Back-to-back with in_valid held high.
        wait_ready();
        drive(0);
        in_valid = 1'b1;
        tick();
        a = acc_edge;
        d = n_acc;
        drive(1);
        n = 0;
        while (n_acc == d && n < 30) begin
            tick();
            n++;
        end
        in_valid = 1'b0;
        chk_i("b2b_second_accept", n_acc, d + 1);
        chk_i("b2b_first_out_edge", del_edge - a, 11);
        chk_i("b2b_accept_after_out", acc_edge - del_edge, 1);
        d = n_del;
        wait_valid();
        tick();
        chk_i("b2b_second_delivered", n_del, d + 1);

        // Flush in the middle of round 5.
        wait_ready();
        drive(0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (round_idx != 4'd5 && n < 20) begin
            tick();
            n++;
        end
        chk_i("flush_reach_r5", int'(round_idx), 5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_i("flush_ready", int'(in_ready), 1);
        chk_i("flush_busy", int'(busy), 0);
        chk_i("flush_round_idx", int'(round_idx), 0);
        seen = 0;
        repeat (12) begin
            seen += int'(out_valid);
            tick();
        end
        chk_i("flush_no_output", seen, 0);
        run_block(0, 1'b0);

        // Flush coincident with an accept in IDLE.
        d = n_acc;
        drive(1);
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk_i("flush_idle_ready", int'(in_ready), 1);
        chk_i("flush_idle_busy", int'(busy), 0);
        chk_i("flush_idle_noacc", n_acc, d);

        // Flush coincident with the output handshake.
        drive(1);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        wait_valid();
        d = n_del;
        flush     = 1'b1;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        chk_i("flush_done_nodel", n_del, d);
        chk_i("flush_done_valid", int'(out_valid), 0);
        chk_i("flush_done_ready", int'(in_ready), 1);

        // Reset during round 3.
        drive(2);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (round_idx != 4'd3 && n < 20) begin
            tick();
            n++;
        end
        chk_i("rst_reach_r3", int'(round_idx), 3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_reset();
        run_block(3, 1'b0);

        // Reset while DONE is backpressured.
        drive(1);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        wait_valid();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_reset();
        run_block(1, 1'b0);

        chk_i("queue_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
